best_delay_param: RTL and testbench
===================================

Name: best_delay_param

Overview:
- Parametrised successor to the ALCT trigger-path delay buffer.
- A circular RAM delays an arbitrary-width data word by a programmable number of clocks and tracks a per-entry valid bit.
- Produces an L1A-window OR of valid bits around the delayed sample, and on each L1A latches a hit flag plus a population count of valid entries in the window.
- Sits between pattern/hit finding and the L1A readout logic; one instance per data stream.

Parameters:
- DATA_W, 34: width of din/dout.
- ADDR_W, 8: buffer depth = 2**ADDR_W entries.
- WIN_W, 4: width of l1a_window; max window = 2**WIN_W-1.
- WIN_LEAD, 8: window entries taken from samples newer than the delayed one (centres window).
- WIN_DEF, 10: window used when l1a_window == 0.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  DATA_W  data word to delay.
- we  in  1  write enable for din and valid.
- valid  in  1  valid flag stored with din.
- delay  in  ADDR_W  delay in clocks; legal 2..2**ADDR_W-1.
- l1a_window  in  WIN_W  L1A window length in clocks; 0 selects WIN_DEF.
- trig_stop  in  1  flush: clear valid history, restart pointers.
- l1a  in  1  L1A strobe, one clock.
- dout  out  DATA_W  delayed data word.
- dout_valid  out  1  valid bit stored with dout.
- valor  out  1  OR of valid over the current window.
- l1a_strobe  out  1  one-clock pulse, the cycle after l1a.
- l1a_hit  out  1  valor captured at l1a.
- l1a_vcount  out  WIN_W  number of valid entries in window at l1a.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset (rst=1): write pointer = 0; all 2**ADDR_W valid bits = 0; window shift register = 0; all outputs = 0. RAM data is not cleared.
- Write: write pointer wp increments every clock not in rst/trig_stop, wrapping 2**ADDR_W-1 -> 0.
  - we=1: mem[wp] <= din; vbit[wp] <= valid.
  - we=0: vbit[wp] <= 0 (stale valid from a previous lap must never reappear); mem is untouched.
- Define V(t) = we&valid at cycle t, or 0 if t precedes the last rst/trig_stop.
- Delay: dout(n) = din(n-delay) and dout_valid(n) = V(n-delay), registered. Total latency from din to dout is exactly delay clocks.
  - delay < 2 clamps to 2.
  - A delay change takes effect on the next clock; the output may skip or repeat samples during the change.
- Window: W = l1a_window, or WIN_DEF if l1a_window == 0. Window k-range is k = -WIN_LEAD .. W-1-WIN_LEAD.
  - valor(n) = OR of V(n-delay-k) over the window.
  - popcount(n) = sum of the same terms, saturating at 2**WIN_W-1.
  - Requires delay >= WIN_LEAD+2; for smaller delay, V for future cycles reads as 0 (valor undefined-free but truncated).
  - Implementation: read vbit at address wp-delay+WIN_LEAD into a 2**WIN_W-bit shift register, with pipeline latency compensated so the equation above holds exactly.
- Flush (trig_stop=1, one cycle or longer):
  - Same as rst, except l1a_hit/l1a_vcount hold their values.
  - valor and dout_valid are 0 from the following clock until new valids age through.
  - trig_stop and rst simultaneous: rst wins.
- L1A: l1a high at cycle n gives, at n+1:
  - l1a_strobe = 1;
  - l1a_hit = valor(n);
  - l1a_vcount = popcount(n).
  - l1a_hit and l1a_vcount hold until the next l1a.
  - Back-to-back l1a: each cycle captures independently.
  - l1a during trig_stop: ignored (no strobe).
- Wrap: pointer wrap is transparent; delay = 2**ADDR_W-1 returns the sample written 2**ADDR_W-1 clocks earlier.

Test Plan:
- Latency: rst, then delay=5, we=1, din=counter from 0 -> dout equals counter-5 from cycle 5; dout_valid tracks valid pattern shifted 5.
- Window: delay=40, l1a_window=3, WIN_LEAD=8, single valid at cycle 100 -> valor high exactly at cycles 132..134 (k=-8..-6 gives n = 100+40-8 ... 100+40-6), 0 elsewhere.
- L1A counts: delay=40, l1a_window=0 (W=10), valid on 4 consecutive cycles inside window, l1a pulsed -> next cycle l1a_strobe=1, l1a_hit=1, l1a_vcount=4.
- Stale clear: delay=255, we=1 valid=1 for one lap, then we=0 for 256+ clocks -> dout_valid and valor 0 after second lap.
- Flush: valids in flight, trig_stop one cycle -> valor=0 next clock; l1a_hit keeps old value; l1a during trig_stop produces no strobe.
- Reset priority: rst and trig_stop together mid-stream -> all outputs 0 including l1a_hit/l1a_vcount; wp restarts at 0.

Source files
------------

// File: rtl/best_delay_param.sv
// best_delay_param
// Programmable-depth delay buffer for one trigger-path data stream.
// A circular RAM delays din by `delay` clocks. A valid bit is kept for each
// entry. A shift register of valid bits, read ahead of the delayed sample,
// forms an L1A window. From that window the block produces a running OR
// (valor). On each L1A it also latches a hit flag and a count of valid entries.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   din         data word to delay (DATA_W)
//   we          write enable for din/valid
//   valid       valid flag stored with din
//   delay       delay in clocks, 2..2**ADDR_W-1 (smaller values clamp to 2)
//   l1a_window  window length, 0 selects WIN_DEF
//   trig_stop   flush valid history and restart pointers
//   l1a         L1A strobe
//   dout        delayed data word (DATA_W)
//   dout_valid  valid bit stored with dout
//   valor       OR of valid bits over the current window
//   l1a_strobe  one-clock pulse the cycle after an accepted l1a
//   l1a_hit     valor captured at l1a
//   l1a_vcount  valid entries in the window captured at l1a (WIN_W)
module best_delay_param #(
    parameter int unsigned DATA_W   = 34,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned WIN_W    = 4,
    parameter int unsigned WIN_LEAD = 8,
    parameter int unsigned WIN_DEF  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              we,
    input  logic              valid,
    input  logic [ADDR_W-1:0] delay,
    input  logic [WIN_W-1:0]  l1a_window,
    input  logic              trig_stop,
    input  logic              l1a,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              valor,
    output logic              l1a_strobe,
    output logic              l1a_hit,
    output logic [WIN_W-1:0]  l1a_vcount
);

    localparam int unsigned DEPTH       = 2 ** ADDR_W;
    localparam int unsigned SR_W        = 2 ** WIN_W;
    localparam int unsigned CNT_W       = WIN_W + 1;
    localparam int unsigned CNT_MAX     = (2 ** WIN_W) - 1;
    localparam int unsigned MIN_DLY     = 2;
    localparam int unsigned WIN_MIN_DLY = WIN_LEAD + 2;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  vbit_q, vbit_d;
    logic [ADDR_W-1:0] wp_q, wp_d;
    logic [SR_W-1:0]   sr_q, sr_d;

    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              valor_q, valor_d;
    logic              strobe_q, strobe_d;
    logic              hit_q, hit_d;
    logic [WIN_W-1:0]  vcount_q, vcount_d;

    logic [ADDR_W-1:0] dly_eff;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] win_addr;
    logic              win_ok;
    logic              win_bit;
    logic [WIN_W-1:0]  win_len;
    logic [SR_W-1:0]   win_mask;
    logic [SR_W-1:0]   sr_shift;
    logic [CNT_W-1:0]  pop_cnt;
    logic [WIN_W-1:0]  pop_sat;

    // Address generation and window bookkeeping
    always_comb begin
        dly_eff  = (delay < ADDR_W'(MIN_DLY)) ? ADDR_W'(MIN_DLY) : delay;
        // Output is registered, so read one entry newer than wp-delay
        rd_addr  = wp_q - dly_eff + ADDR_W'(1);
        // Window head is WIN_LEAD samples newer, plus one for the shift register stage
        win_addr = wp_q - dly_eff + ADDR_W'(WIN_LEAD + 1);
        // Too short a delay would read entries not yet written this lap; treat them as 0
        win_ok   = (dly_eff >= ADDR_W'(WIN_MIN_DLY));
        win_bit  = win_ok & vbit_q[win_addr];
        sr_shift = {sr_q[SR_W-2:0], win_bit};
        win_len  = (l1a_window == '0) ? WIN_W'(WIN_DEF) : l1a_window;
        win_mask = '0;
        for (int unsigned j = 0; j < SR_W; j++) begin
            win_mask[j] = (WIN_W'(j) < win_len);
        end
    end

    // Population count of the window as it stands this cycle, saturating
    always_comb begin
        pop_cnt = '0;
        for (int unsigned j = 0; j < SR_W; j++) begin
            pop_cnt = pop_cnt + CNT_W'(sr_q[j] & win_mask[j]);
        end
        pop_sat = (pop_cnt > CNT_W'(CNT_MAX)) ? WIN_W'(CNT_MAX) : pop_cnt[WIN_W-1:0];
    end

    // Next-state logic
    always_comb begin
        wp_d          = wp_q + ADDR_W'(1);
        vbit_d        = vbit_q;
        vbit_d[wp_q]  = we & valid;
        sr_d          = sr_shift;
        dout_d        = mem_q[rd_addr];
        dout_valid_d  = vbit_q[rd_addr];
        valor_d       = |(sr_shift & win_mask);
        strobe_d      = l1a;
        hit_d         = hit_q;
        vcount_d      = vcount_q;
        if (l1a) begin
            hit_d    = |(sr_q & win_mask);
            vcount_d = pop_sat;
        end
        // Flush behaves like reset but keeps the last L1A capture
        if (trig_stop) begin
            wp_d         = '0;
            vbit_d       = '0;
            sr_d         = '0;
            dout_d       = '0;
            dout_valid_d = 1'b0;
            valor_d      = 1'b0;
            strobe_d     = 1'b0;
            hit_d        = hit_q;
            vcount_d     = vcount_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q         <= '0;
            vbit_q       <= '0;
            sr_q         <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            valor_q      <= 1'b0;
            strobe_q     <= 1'b0;
            hit_q        <= 1'b0;
            vcount_q     <= '0;
        end else begin
            wp_q         <= wp_d;
            vbit_q       <= vbit_d;
            sr_q         <= sr_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            valor_q      <= valor_d;
            strobe_q     <= strobe_d;
            hit_q        <= hit_d;
            vcount_q     <= vcount_d;
        end
    end

    // Data RAM, never cleared
    always_ff @(posedge clk) begin
        if (!rst && !trig_stop && we) begin
            mem_q[wp_q] <= din;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign valor      = valor_q;
    assign l1a_strobe = strobe_q;
    assign l1a_hit    = hit_q;
    assign l1a_vcount = vcount_q;

endmodule

// File: tb/tb_best_delay_param.sv
// Directed testbench for best_delay_param: latency, delay clamp, window
// placement, L1A capture, stale-valid clearing, flush and reset priority.
module tb_best_delay_param;

    localparam int unsigned DATA_W = 34;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned WIN_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] din;
    logic              we;
    logic              valid;
    logic [ADDR_W-1:0] delay;
    logic [WIN_W-1:0]  l1a_window;
    logic              trig_stop;
    logic              l1a;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              valor;
    logic              l1a_strobe;
    logic              l1a_hit;
    logic [WIN_W-1:0]  l1a_vcount;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    best_delay_param dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .we         (we),
        .valid      (valid),
        .delay      (delay),
        .l1a_window (l1a_window),
        .trig_stop  (trig_stop),
        .l1a        (l1a),
        .dout       (dout),
        .dout_valid (dout_valid),
        .valor      (valor),
        .l1a_strobe (l1a_strobe),
        .l1a_hit    (l1a_hit),
        .l1a_vcount (l1a_vcount)
    );

    function automatic logic [DATA_W-1:0] dval(input int n);
        logic [31:0] lo;
        logic [1:0]  hi;
        lo = 32'(n) ^ 32'hA5A5_0000;
        hi = 2'(n % 4);
        return {hi, lo};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        din        = '0;
        we         = 1'b0;
        valid      = 1'b0;
        delay      = 8'd5;
        l1a_window = '0;
        trig_stop  = 1'b0;
        l1a        = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state and delay-5 latency
        chk("rst_dout",       64'(dout), 64'd0);
        chk("rst_dout_valid", 64'(dout_valid), 64'd0);
        chk("rst_valor",      64'(valor), 64'd0);
        chk("rst_strobe",     64'(l1a_strobe), 64'd0);
        chk("rst_hit",        64'(l1a_hit), 64'd0);
        chk("rst_vcount",     64'(l1a_vcount), 64'd0);
        we = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (n >= 5 && n < 31) begin
                chk("lat_dout", 64'(dout), 64'(dval(n - 5)));
                chk("lat_dv", 64'(dout_valid), 64'(((n - 5) % 3) == 1));
            end else if (n >= 1 && n < 5) begin
                chk("lat_dv_early", 64'(dout_valid), 64'd0);
            end else if (n >= 32) begin
                chk("clamp_dout", 64'(dout), 64'(dval(n - 2)));
                chk("clamp_dv", 64'(dout_valid), 64'(((n - 2) % 3) == 1));
            end
            din   = dval(n);
            valid = ((n % 3) == 1);
            if (n == 30) delay = 8'd0;
            step();
        end

        // Window placement: delay 40, window 3, single valid at cycle 100
        rst        = 1'b1;
        delay      = 8'd40;
        l1a_window = 4'd3;
        valid      = 1'b0;
        step();
        rst = 1'b0;
        for (int n = 0; n <= 200; n++) begin
            chk("win_valor", 64'(valor), 64'(n >= 132 && n <= 134));
            chk("win_dv", 64'(dout_valid), 64'(n == 140));
            valid = (n == 100);
            step();
        end

        // L1A capture: default window 10, valids at 100..103
        rst        = 1'b1;
        l1a_window = 4'd0;
        valid      = 1'b0;
        step();
        rst = 1'b0;
        for (int n = 0; n <= 160; n++) begin
            chk("l1a_valor", 64'(valor), 64'(n >= 132 && n <= 144));
            if (n == 134) begin
                chk("l1a134_strobe", 64'(l1a_strobe), 64'd1);
                chk("l1a134_hit", 64'(l1a_hit), 64'd1);
                chk("l1a134_cnt", 64'(l1a_vcount), 64'd2);
            end
            if (n == 135) begin
                chk("l1a135_strobe", 64'(l1a_strobe), 64'd1);
                chk("l1a135_cnt", 64'(l1a_vcount), 64'd3);
            end
            if (n == 136) begin
                chk("l1a136_strobe", 64'(l1a_strobe), 64'd0);
                chk("l1a136_hit_hold", 64'(l1a_hit), 64'd1);
                chk("l1a136_cnt_hold", 64'(l1a_vcount), 64'd3);
            end
            if (n == 139) begin
                chk("l1a139_strobe", 64'(l1a_strobe), 64'd1);
                chk("l1a139_hit", 64'(l1a_hit), 64'd1);
                chk("l1a139_cnt", 64'(l1a_vcount), 64'd4);
            end
            if (n == 151) begin
                chk("l1a151_strobe", 64'(l1a_strobe), 64'd1);
                chk("l1a151_hit", 64'(l1a_hit), 64'd0);
                chk("l1a151_cnt", 64'(l1a_vcount), 64'd0);
            end
            valid = (n >= 100 && n <= 103);
            l1a   = (n == 133 || n == 134 || n == 138 || n == 150);
            step();
        end
        l1a = 1'b0;

        // Stale clear and wrap: delay 255, one lap of valids, then we=0
        rst   = 1'b1;
        delay = 8'd255;
        step();
        rst = 1'b0;
        for (int n = 0; n < 600; n++) begin
            chk("stale_dv", 64'(dout_valid), 64'(n >= 255 && n <= 510));
            chk("stale_valor", 64'(valor), 64'(n >= 247 && n <= 511));
            if (n >= 255 && n <= 510) begin
                chk("wrap_dout", 64'(dout), 64'(dval(n - 255)));
            end
            we    = (n < 256);
            valid = 1'b1;
            din   = dval(n);
            step();
        end

        // Flush and reset priority: delay 40, default window
        rst   = 1'b1;
        delay = 8'd40;
        we    = 1'b1;
        valid = 1'b0;
        step();
        rst = 1'b0;
        for (int n = 0; n <= 230; n++) begin
            if (n == 139) begin
                chk("fl139_hit", 64'(l1a_hit), 64'd1);
                chk("fl139_cnt", 64'(l1a_vcount), 64'd4);
            end
            if (n == 141) chk("fl141_valor", 64'(valor), 64'd1);
            if (n == 142) begin
                chk("fl142_valor", 64'(valor), 64'd0);
                chk("fl142_dv", 64'(dout_valid), 64'd0);
                chk("fl142_strobe", 64'(l1a_strobe), 64'd0);
                chk("fl142_hit_hold", 64'(l1a_hit), 64'd1);
                chk("fl142_cnt_hold", 64'(l1a_vcount), 64'd4);
            end
            if (n >= 142) begin
                chk("fl_valor", 64'(valor), 64'(n >= 182 && n <= 188));
                chk("fl_dv", 64'(dout_valid), 64'd0);
            end
            if (n == 187) begin
                chk("fl187_strobe", 64'(l1a_strobe), 64'd1);
                chk("fl187_hit", 64'(l1a_hit), 64'd1);
                chk("fl187_cnt", 64'(l1a_vcount), 64'd1);
            end
            if (n == 189) begin
                chk("rp_dout", 64'(dout), 64'd0);
                chk("rp_strobe", 64'(l1a_strobe), 64'd0);
                chk("rp_hit", 64'(l1a_hit), 64'd0);
                chk("rp_cnt", 64'(l1a_vcount), 64'd0);
                chk("rp_wp", 64'(dut.wp_q), 64'd0);
            end
            valid     = (n >= 100 && n <= 103) || (n == 150);
            l1a       = (n == 138 || n == 141 || n == 186);
            trig_stop = (n == 141 || n == 188);
            rst       = (n == 188);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
